// File: rtl/alu_share_ctrl.sv
// Shares one combinational ALU between two requesters. Grants are round-robin,
// one operation is in flight at a time, and each result returns with its requester ID.
module alu_share_ctrl #(
  parameter bit MASK_SHAMT = 1'b1
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        req0_valid_in,
  input  logic [3:0]  req0_opcode_in,
  input  logic [31:0] req0_op_1_in,
  input  logic [31:0] req0_op_2_in,
  output logic        req0_ready_out,
  input  logic        req1_valid_in,
  input  logic [3:0]  req1_opcode_in,
  input  logic [31:0] req1_op_1_in,
  input  logic [31:0] req1_op_2_in,
  output logic        req1_ready_out,
  output logic        resp_valid_out,
  output logic        resp_id_out,
  output logic [31:0] resp_result_out,
  output logic        resp_err_out,
  input  logic        resp_ready_in,
  output logic        busy_out
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StExec = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  logic [1:0]  state_q, state_d;
  logic        prio_q;
  logic [3:0]  opc_q;
  logic [31:0] op1_q, op2_q;
  logic        id_q;
  logic        resp_id_q, resp_err_q;
  logic [31:0] resp_result_q;

  logic        is_idle, grant0, grant1, acc0, acc1, accept;
  logic [3:0]  sel_opc;
  logic [31:0] sel_op1, sel_op2, sel_op2_m;
  logic [31:0] alu_y, result_norm;
  logic        legal;

  assign is_idle = (state_q == StIdle);
  // Lone requester wins outright; prio only breaks ties.
  assign grant0  = req0_valid_in & (~req1_valid_in | ~prio_q);
  assign grant1  = req1_valid_in & (~req0_valid_in | prio_q);
  assign req0_ready_out = is_idle & grant0;
  assign req1_ready_out = is_idle & grant1;
  assign acc0   = req0_valid_in & req0_ready_out;
  assign acc1   = req1_valid_in & req1_ready_out;
  assign accept = acc0 | acc1;

  assign sel_opc = acc1 ? req1_opcode_in : req0_opcode_in;
  assign sel_op1 = acc1 ? req1_op_1_in   : req0_op_1_in;
  assign sel_op2 = acc1 ? req1_op_2_in   : req0_op_2_in;

  always_comb begin
    sel_op2_m = sel_op2;
    if (MASK_SHAMT && (sel_opc == 4'b0001 || sel_opc == 4'b0101 || sel_opc == 4'b1101)) begin
      sel_op2_m = {27'd0, sel_op2[4:0]};
    end
  end

  // alu_unit: opcode is {funct7[5], funct3}
  always_comb begin
    alu_y = 32'd0;
    legal = 1'b1;
    case (opc_q)
      4'b0000: alu_y = op1_q + op2_q;
      4'b1000: alu_y = op1_q - op2_q;
      4'b0010: alu_y = {31'd0, $signed(op1_q) < $signed(op2_q)};
      4'b0011: alu_y = {31'd0, op1_q < op2_q};
      4'b0111: alu_y = op1_q & op2_q;
      4'b0110: alu_y = op1_q | op2_q;
      4'b0100: alu_y = op1_q ^ op2_q;
      4'b0001: alu_y = op1_q << op2_q;
      4'b0101: alu_y = op1_q >> op2_q;
      4'b1101: alu_y = $signed(op1_q) >>> op2_q;
      default: legal = 1'b0;
    endcase
  end

  always_comb begin
    result_norm = alu_y;
    if (!legal) begin
      result_norm = 32'd0;
    end else if (opc_q == 4'b0010 || opc_q == 4'b0011) begin
      result_norm = {31'd0, |alu_y};
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (accept) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (resp_ready_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q       <= StIdle;
      prio_q        <= 1'b0;
      opc_q         <= 4'd0;
      op1_q         <= 32'd0;
      op2_q         <= 32'd0;
      id_q          <= 1'b0;
      resp_id_q     <= 1'b0;
      resp_result_q <= 32'd0;
      resp_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        opc_q  <= sel_opc;
        op1_q  <= sel_op1;
        op2_q  <= sel_op2_m;
        id_q   <= acc1;
        prio_q <= acc0;
      end
      if (state_q == StExec) begin
        resp_id_q     <= id_q;
        resp_result_q <= result_norm;
        resp_err_q    <= ~legal;
      end
    end
  end

  assign resp_valid_out  = (state_q == StResp);
  assign resp_id_out     = resp_id_q;
  assign resp_result_out = resp_result_q;
  assign resp_err_out    = resp_err_q;
  assign busy_out        = ~is_idle;

endmodule

// File: tb/tb_alu_share_ctrl.sv
// Scoreboard bench for alu_share_ctrl: accepts push hand-computed expectations,
// and a response monitor pops and compares them.
module tb_alu_share_ctrl;

  typedef struct packed {
    logic        id;
    logic [31:0] res;
    logic        err;
  } exp_t;

  logic        clk_in, rst_in;
  logic        req0_valid_in, req0_ready_out, req1_valid_in, req1_ready_out;
  logic [3:0]  req0_opcode_in, req1_opcode_in;
  logic [31:0] req0_op_1_in, req0_op_2_in, req1_op_1_in, req1_op_2_in;
  logic        resp_valid_out, resp_id_out, resp_err_out, resp_ready_in, busy_out;
  logic [31:0] resp_result_out;

  exp_t exp0, exp1;
  exp_t sb_q[$];
  int   checks, failures;

  alu_share_ctrl #(.MASK_SHAMT(1'b1)) dut (
    .clk_in(clk_in), .rst_in(rst_in),
    .req0_valid_in(req0_valid_in), .req0_opcode_in(req0_opcode_in),
    .req0_op_1_in(req0_op_1_in), .req0_op_2_in(req0_op_2_in), .req0_ready_out(req0_ready_out),
    .req1_valid_in(req1_valid_in), .req1_opcode_in(req1_opcode_in),
    .req1_op_1_in(req1_op_1_in), .req1_op_2_in(req1_op_2_in), .req1_ready_out(req1_ready_out),
    .resp_valid_out(resp_valid_out), .resp_id_out(resp_id_out),
    .resp_result_out(resp_result_out), .resp_err_out(resp_err_out),
    .resp_ready_in(resp_ready_in), .busy_out(busy_out)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk_in) begin
    if (!rst_in) begin
      if (req0_valid_in && req0_ready_out) sb_q.push_back(exp0);
      if (req1_valid_in && req1_ready_out) sb_q.push_back(exp1);
    end
  end

  always @(negedge clk_in) begin
    if (!rst_in && resp_valid_out && resp_ready_in) begin
      if (sb_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL sb_unexpected: got response id %0d with empty scoreboard", resp_id_out);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("resp_id", {31'd0, resp_id_out}, {31'd0, e.id});
        check("resp_result", resp_result_out, e.res);
        check("resp_err", {31'd0, resp_err_out}, {31'd0, e.err});
      end
    end
  end

  task automatic go(input int which, input logic [3:0] opc, input logic [31:0] a,
                    input logic [31:0] b, input logic [31:0] res, input logic err);
    if (which == 0) begin
      exp0 = '{id: 1'b0, res: res, err: err};
      req0_opcode_in = opc; req0_op_1_in = a; req0_op_2_in = b; req0_valid_in = 1'b1;
    end else begin
      exp1 = '{id: 1'b1, res: res, err: err};
      req1_opcode_in = opc; req1_op_1_in = a; req1_op_2_in = b; req1_valid_in = 1'b1;
    end
  endtask

  // Returns 1ns after the accepting edge.
  task automatic wait_accept(input int which);
    for (int i = 0; i < 30; i++) begin
      @(negedge clk_in);
      if ((which == 0 && req0_ready_out) || (which == 1 && req1_ready_out)) begin
        @(posedge clk_in);
        #1;
        if (which == 0) req0_valid_in = 1'b0;
        else req1_valid_in = 1'b0;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL accept_timeout: requester %0d never accepted, required within 30 cycles", which);
    if (which == 0) req0_valid_in = 1'b0;
    else req1_valid_in = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_in);
      if (!busy_out && !req0_valid_in && !req1_valid_in) begin
        @(posedge clk_in);
        #1;
        return;
      end
    end
    checks++;
    failures++;
    $display("FAIL idle_timeout: busy_out still %0d, required 0 within 50 cycles", busy_out);
  endtask

  initial begin
    checks = 0; failures = 0;
    rst_in = 1'b1; resp_ready_in = 1'b1;
    req0_valid_in = 1'b0; req0_opcode_in = '0; req0_op_1_in = '0; req0_op_2_in = '0;
    req1_valid_in = 1'b0; req1_opcode_in = '0; req1_op_1_in = '0; req1_op_2_in = '0;
    exp0 = '0; exp1 = '0;
    #2;
    check("rst_resp_valid", {31'd0, resp_valid_out}, 32'd0);
    check("rst_resp_id", {31'd0, resp_id_out}, 32'd0);
    check("rst_resp_result", resp_result_out, 32'd0);
    check("rst_resp_err", {31'd0, resp_err_out}, 32'd0);
    check("rst_busy", {31'd0, busy_out}, 32'd0);
    check("rst_readies", {30'd0, req1_ready_out, req0_ready_out}, 32'd0);
    @(posedge clk_in); #1;
    rst_in = 1'b0;

    // Lone req0, latency and busy profile
    go(0, 4'b0000, 32'd5, 32'd7, 32'd12, 1'b0);
    wait_accept(0);
    check("lat_exec_valid", {31'd0, resp_valid_out}, 32'd0);
    check("lat_exec_busy", {31'd0, busy_out}, 32'd1);
    @(posedge clk_in); #1;
    check("lat_resp_valid", {31'd0, resp_valid_out}, 32'd1);
    check("lat_resp_busy", {31'd0, busy_out}, 32'd1);
    @(posedge clk_in); #1;
    check("lat_done_valid", {31'd0, resp_valid_out}, 32'd0);
    check("lat_done_busy", {31'd0, busy_out}, 32'd0);

    // Both valid right after reset: req0 first, then req1
    rst_in = 1'b1;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    go(0, 4'b1000, 32'd3, 32'd5, 32'hFFFF_FFFE, 1'b0);
    go(1, 4'b0111, 32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0);
    #1;
    check("dual_grant_after_rst", {30'd0, req1_ready_out, req0_ready_out}, 32'd1);
    wait_accept(0);
    wait_accept(1);

    go(1, 4'b0010, 32'hFFFF_FFFF, 32'd2, 32'd1, 1'b0);
    wait_accept(1);
    go(1, 4'b0011, 32'hFFFF_FFFF, 32'd2, 32'd0, 1'b0);
    wait_accept(1);
    go(0, 4'b0001, 32'd1, 32'h0000_0021, 32'd2, 1'b0);
    wait_accept(0);
    wait_idle();

    // prio now points at req1
    go(0, 4'b0101, 32'h8000_0000, 32'd4, 32'h0800_0000, 1'b0);
    go(1, 4'b1101, 32'h8000_0000, 32'd4, 32'hF800_0000, 1'b0);
    #1;
    check("dual_grant_prio1", {30'd0, req1_ready_out, req0_ready_out}, 32'd2);
    wait_accept(1);
    wait_accept(0);
    go(1, 4'b1111, 32'h12, 32'h34, 32'd0, 1'b1);
    wait_accept(1);
    go(0, 4'b0110, 32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0);
    wait_accept(0);
    go(0, 4'b0100, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0, 1'b0);
    wait_accept(0);
    wait_idle();

    // Back-pressure, then asynchronous reset in RESP
    resp_ready_in = 1'b0;
    go(0, 4'b0000, 32'h10, 32'h20, 32'h30, 1'b0);
    wait_accept(0);
    go(1, 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
    @(posedge clk_in); #1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_in);
      check("hold_valid", {31'd0, resp_valid_out}, 32'd1);
      check("hold_result", resp_result_out, 32'h30);
      check("hold_id", {31'd0, resp_id_out}, 32'd0);
      check("hold_readies", {30'd0, req1_ready_out, req0_ready_out}, 32'd0);
    end
    @(posedge clk_in); #1;
    req1_valid_in = 1'b0;
    check("hold_sb_depth", sb_q.size(), 32'd1);
    #2;
    rst_in = 1'b1;
    #1;
    check("async_rst_valid", {31'd0, resp_valid_out}, 32'd0);
    check("async_rst_busy", {31'd0, busy_out}, 32'd0);
    check("async_rst_result", resp_result_out, 32'd0);
    sb_q.delete();
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    resp_ready_in = 1'b1;

    go(0, 4'b0000, 32'd1, 32'd1, 32'd2, 1'b0);
    go(1, 4'b0100, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555, 1'b0);
    #1;
    check("prio_after_rst", {30'd0, req1_ready_out, req0_ready_out}, 32'd1);
    wait_accept(0);
    wait_accept(1);
    wait_idle();
    check("sb_empty", sb_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish, required finish before 200000");
    $fatal(1);
  end

endmodule
